npu_host_master: RTL and testbench
==================================

Name: npu_host_master

Overview:
- Host-side initiator for the NPU memory-mapped port (ena/wea/addra/dina/douta): the end that issues accesses rather than answering them.
- Accepts a stream of write, read and poll commands and converts each into correctly timed NPU port cycles.
- Returns read/poll data on a valid/ready response channel.
- Sits between the testbench or system controller and the npu block, replacing hand-written bus sequencing.

Parameters:
ADDR_W, 16, width of cmd_addr/addra
DATA_W, 32, width of cmd_data/dina/douta/rsp_data
POLL_MAX, 1024, maximum read attempts per poll command (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved (treated as write-nothing / no-op)
cmd_addr  in  ADDR_W  target address
cmd_data  in  DATA_W  write data (ignored for read/poll)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_data  out  DATA_W  captured douta
rsp_err  out  1  poll timed out (valid with rsp_valid)
busy  out  1  state != S_IDLE or rsp_valid
ena  out  1  NPU port enable
wea  out  1  NPU write enable
addra  out  ADDR_W  NPU address
dina  out  DATA_W  NPU write data
douta  in  DATA_W  NPU read data, registered by NPU one cycle after a read access

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high. While rst is sampled high, all state clears: state=S_IDLE; ena, wea, rsp_valid and rsp_err are 0; addra, dina and rsp_data are 0; the attempt counter is 0. A reset mid-access aborts the access with no response; ena is 0 from the cycle after rst is sampled.
- cmd_ready = (state==S_IDLE) && !rsp_valid. This gives one outstanding command at most.
- ena, wea, addra and dina are registered outputs driven from FSM state.
- FSM states: S_IDLE, S_WR, S_GAP, S_RD, S_CAP.
  - S_IDLE: on handshake, latch op/addr/data. Write goes to S_WR, read or poll goes to S_RD, reserved op stays in S_IDLE.
  - S_WR: ena=1, wea=1, addra=addr, dina=data for exactly one cycle, then S_GAP.
  - S_GAP: ena=0 for one cycle, then S_IDLE. This mandatory idle cycle lets the NPU clear its single-cycle control pulses (trigger/next/clear bits), so back-to-back writes never merge.
  - S_RD: ena=1, wea=0, addra=addr for one cycle, then S_CAP.
  - S_CAP: ena=0. douta is valid this cycle. For read: rsp_data<=douta, rsp_valid<=1, rsp_err<=0, go to S_IDLE. For poll: if douta[0]==1, respond as for read. Otherwise increment the attempt counter and return to S_RD.
- Response: rsp_valid stays high with stable rsp_data/rsp_err until rsp_ready. It clears on the handshake cycle. No new command is accepted while rsp_valid is high.
- Latency from command handshake at cycle N:
  - write: port access at N+1, cmd_ready again at N+3.
  - read: port access at N+1, rsp_valid at N+3.
  - poll: succeeding on attempt k (1-based), rsp_valid at N+1+2k.
- The attempt counter is wide enough for POLL_MAX and resets to 0 at each poll command.

Optional Feature:
NPU_HOST_POLL_TIMEOUT_EN:
- Defined: in S_CAP for a poll, if douta[0]==0 and the attempt count reaches POLL_MAX, respond with rsp_data=last douta and rsp_err=1, then go to S_IDLE.
- Not defined: poll retries indefinitely, rsp_err is tied 0, and POLL_MAX is unused.

Test Plan:
- Reset: assert rst for 2 cycles during an S_RD access -> next cycle ena=0, wea=0, rsp_valid=0, cmd_ready=1.
- Write: cmd_op=00, addr=0x4000, data=0x00000001 -> exactly one cycle with ena=1, wea=1, addra=0x4000, dina=1, then one cycle ena=0; cmd_ready low for 2 cycles.
- Read: cmd_op=01, addr=0x6000, bench npu model returns douta=0x00ABCDEF one cycle later -> rsp_valid at N+3, rsp_data=0x00ABCDEF, rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_data stable, cmd_ready=0; release -> rsp_valid drops the cycle after the handshake, cmd_ready returns.
- Poll success: cmd_op=10, addr=0x7000, douta[0]=0 for 3 reads then 1 -> four read accesses separated by one idle cycle, rsp_valid at N+9, rsp_err=0.
- Poll timeout (macro on, POLL_MAX=4): douta=0 always -> 4 read accesses, then rsp_err=1, rsp_data=0.

Source files
------------

// File: rtl/npu_host_master.sv
// npu_host_master
//   Host-side initiator for the NPU memory-mapped port. Accepts one write,
//   read or poll command at a time and turns it into timed ena/wea/addra/dina
//   cycles. Read and poll results return on a valid/ready response channel.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op                     00 write, 01 read, 10 poll, 11 no-op
//   cmd_addr, cmd_data         target address, write data
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          captured douta, poll timeout flag
//   busy                       FSM active or response pending
//   ena, wea, addra, dina      NPU port (registered)
//   douta                      NPU read data, one cycle after a read access
//
// Optional feature (macro NPU_HOST_POLL_TIMEOUT_EN)
//   Defined:   a poll that still reads douta[0]==0 after POLL_MAX attempts
//              responds with the last douta and rsp_err=1.
//   Undefined: polls retry indefinitely and rsp_err is tied 0.

module npu_host_master #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_RD,
    S_CAP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_is_poll;
  logic [CNT_W-1:0]   r_attempt;
  logic               r_ena;
  logic               r_wea;
  logic [ADDR_W-1:0]  r_addra;
  logic [DATA_W-1:0]  r_dina;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               w_hs;
  logic               w_cmd_ready;
  logic               w_rsp_load;
  logic               w_attempt_inc;

  assign w_cmd_ready = (r_state == S_IDLE) && !r_rsp_valid;
  assign w_hs        = cmd_valid && w_cmd_ready;

`ifdef NPU_HOST_POLL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);
  logic r_rsp_err;
  logic w_rsp_err_nxt;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_rsp_load    = 1'b0;
    w_attempt_inc = 1'b0;
`ifdef NPU_HOST_POLL_TIMEOUT_EN
    w_rsp_err_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          case (cmd_op)
            2'b00:        w_state_nxt = S_WR;
            2'b01, 2'b10: w_state_nxt = S_RD;
            default:      w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_WR:  w_state_nxt = S_GAP;
      S_GAP: w_state_nxt = S_IDLE;
      S_RD:  w_state_nxt = S_CAP;
      S_CAP: begin
        if (!r_is_poll || douta[0]) begin
          w_rsp_load  = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef NPU_HOST_POLL_TIMEOUT_EN
        // r_attempt counts failed attempts before this one, so this is attempt POLL_MAX
        else if (r_attempt == POLL_LAST) begin
          w_rsp_load    = 1'b1;
          w_rsp_err_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
`endif
        else begin
          w_attempt_inc = 1'b1;
          w_state_nxt   = S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Port outputs are registered from the next state so the access lands in
  // the same cycle the FSM sits in S_WR / S_RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ena       <= 1'b0;
      r_wea       <= 1'b0;
      r_addra     <= '0;
      r_dina      <= '0;
      r_is_poll   <= 1'b0;
      r_attempt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_ena <= (w_state_nxt == S_WR) || (w_state_nxt == S_RD);
      r_wea <= (w_state_nxt == S_WR);
      if (w_hs && (cmd_op != 2'b11)) begin
        r_addra   <= cmd_addr;
        r_is_poll <= (cmd_op == 2'b10);
      end
      if (w_hs && (cmd_op == 2'b00)) r_dina <= cmd_data;
      if (w_hs)               r_attempt <= '0;
      else if (w_attempt_inc) r_attempt <= r_attempt + 1'b1;
      if (w_rsp_load) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= douta;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef NPU_HOST_POLL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)             r_rsp_err <= 1'b0;
    else if (w_rsp_load) r_rsp_err <= w_rsp_err_nxt;
  end
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE) || r_rsp_valid;
  assign ena       = r_ena;
  assign wea       = r_wea;
  assign addra     = r_addra;
  assign dina      = r_dina;

endmodule

// File: tb/tb_npu_host_master.sv
// tb_npu_host_master
//   Drives write/read/poll commands into npu_host_master against a small NPU
//   model. Expected port accesses and responses are queued when each command
//   is issued and compared by monitors when the DUT produces them.

module tb_npu_host_master;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta = '0;

  always #5 clk = ~clk;

  npu_host_master #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .POLL_MAX (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // NPU model: registered read data; address 0x7000 is a status register
  // whose bit 0 rises after poll_zero_n reads counted from poll_base.
  int poll_reads = 0;
  int poll_base;
  int poll_zero_n;

  always @(posedge clk) begin
    if (ena && !wea) begin
      if (addra == 16'h7000) begin
        douta      <= ((poll_reads - poll_base) >= poll_zero_n) ? 32'h1 : 32'h0;
        poll_reads <= poll_reads + 1;
      end else if (addra == 16'h6000) begin
        douta <= 32'h00AB_CDEF;
      end else begin
        douta <= 32'h5A00_0000 | {16'h0, addra};
      end
    end
  end

  typedef struct packed {
    logic          wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    if (!rst && ena) begin
      if (acc_q.size() == 0) chk("acc_unexpected", 1, 0);
      else begin
        a = acc_q.pop_front();
        chk("acc_wea", wea, a.wea);
        chk("acc_addr", addra, a.addr);
        if (a.wea) chk("acc_dina", dina, a.data);
      end
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_err", rsp_err, r.err);
      end
    end
  end

  // Returns just after the handshake edge, i.e. inside cycle N+1.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Poll sequence: expects accesses at odd offsets and rsp_valid at N+1+2k.
  task automatic run_poll(input int k, input string tag);
    for (int i = 0; i < k; i++) acc_q.push_back('{1'b0, 16'h7000, 32'h0});
    send(2'b10, 16'h7000, 32'h0);
    for (int c = 1; c <= 2 * k + 1; c++) begin
      @(negedge clk);
      if (c <= 2 * k) chk($sformatf("%s_ena_%0d", tag, c), ena, (c % 2));
      chk($sformatf("%s_valid_%0d", tag, c), rsp_valid, (c == 2 * k + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_addr    = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b1;
    poll_base   = 0;
    poll_zero_n = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ena", ena, 0);
    chk("rst_wea", wea, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_rdata", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset for two cycles during the S_RD access of a read
    send(2'b01, 16'h6000, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_ena_next", ena, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ena", ena, 0);
    chk("rstmid_wea", wea, 0);
    chk("rstmid_valid", rsp_valid, 0);
    chk("rstmid_ready", cmd_ready, 1);

    // Single write
    acc_q.push_back('{1'b1, 16'h4000, 32'h0000_0001});
    send(2'b00, 16'h4000, 32'h0000_0001);
    @(negedge clk);
    chk("wr_ena", ena, 1);
    chk("wr_wea", wea, 1);
    chk("wr_ready", cmd_ready, 0);
    @(negedge clk);
    chk("wr_gap_ena", ena, 0);
    chk("wr_gap_ready", cmd_ready, 0);
    @(negedge clk);
    chk("wr_ready_back", cmd_ready, 1);

    // Back-to-back writes stay separate accesses
    acc_q.push_back('{1'b1, 16'h4004, 32'hCAFE_0001});
    acc_q.push_back('{1'b1, 16'h4008, 32'hCAFE_0002});
    send(2'b00, 16'h4004, 32'hCAFE_0001);
    send(2'b00, 16'h4008, 32'hCAFE_0002);
    @(negedge clk);
    chk("wr2_wea", wea, 1);
    @(negedge clk);
    chk("wr2_gap_ena", ena, 0);

    // Reserved op: no access, ready again immediately
    send(2'b11, 16'h1234, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rsv_ena", ena, 0);
    chk("rsv_ready", cmd_ready, 1);
    chk("rsv_busy", busy, 0);

    // Read with immediate consume
    acc_q.push_back('{1'b0, 16'h6000, 32'h0});
    rsp_q.push_back('{32'h00AB_CDEF, 1'b0});
    send(2'b01, 16'h6000, 32'h0);
    @(negedge clk);
    chk("rd_ena_n1", ena, 1);
    @(negedge clk);
    chk("rd_ena_n2", ena, 0);
    chk("rd_valid_n2", rsp_valid, 0);
    @(negedge clk);
    chk("rd_valid_n3", rsp_valid, 1);
    @(negedge clk);
    chk("rd_valid_clr", rsp_valid, 0);
    chk("rd_ready_back", cmd_ready, 1);

    // Read with response backpressure
    rsp_ready = 1'b0;
    acc_q.push_back('{1'b0, 16'h6004, 32'h0});
    rsp_q.push_back('{32'h5A00_6004, 1'b0});
    send(2'b01, 16'h6004, 32'h0);
    repeat (3) @(negedge clk);
    chk("bp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 32'h5A00_6004);
      chk("bp_hold_ready", cmd_ready, 0);
      chk("bp_hold_busy", busy, 1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_clr", rsp_valid, 0);
    chk("bp_ready_back", cmd_ready, 1);

    // Poll succeeding on the fourth read
    poll_base   = poll_reads;
    poll_zero_n = 3;
    rsp_q.push_back('{32'h1, 1'b0});
    run_poll(4, "poll");

`ifdef NPU_HOST_POLL_TIMEOUT_EN
    // Poll that never sees bit 0 set: gives up after POLL_MAX=4 reads
    @(negedge clk);
    poll_base   = poll_reads;
    poll_zero_n = 1000;
    rsp_q.push_back('{32'h0, 1'b1});
    run_poll(4, "ptmo");
`else
    // Without the timeout a poll keeps retrying past POLL_MAX
    @(negedge clk);
    poll_base   = poll_reads;
    poll_zero_n = 5;
    rsp_q.push_back('{32'h1, 1'b0});
    run_poll(6, "plong");
`endif

    repeat (3) @(negedge clk);
    chk("acc_q_empty", acc_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
